// File: rtl/sensor_cond_pkg.sv
// ============================================================================
// Module      : sensor_cond_pkg
// Description : Shared constants and helpers for the sensor conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sensor_cond_pkg;

    localparam int NUM_SENSORS_C    = 8;
    localparam int DEB_CNT_W        = 8;
    localparam int DEBOUNCE_DEFAULT = 4;
    localparam int ACT_CNT_W        = 4;

    function automatic logic [ACT_CNT_W-1:0] popcount(input logic [NUM_SENSORS_C-1:0] v);
        logic [ACT_CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_SENSORS_C; i++) begin
            n = n + ACT_CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sensor_debounce_ch.sv
// ============================================================================
// Module      : sensor_debounce_ch
// Description : One sensor channel: 2-flop sync, debounce counter, clean level,
//               edge strobes and optional sticky glitch flag
//               (SENSOR_GLITCH_LATCH_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sensor_debounce_ch
    import sensor_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    input  logic i_glitch_clr,
    output logic o_clean,
    output logic o_rise,
    output logic o_fall,
    output logic o_glitch
);

    localparam logic [DEB_CNT_W-1:0] c_cnt_max = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                 r_s1;
    logic                 r_s2;
    logic [DEB_CNT_W-1:0] r_cnt;
    logic                 r_clean;
    logic                 r_rise;
    logic                 r_fall;
    logic                 w_differ;
    logic                 w_accept;

    assign w_differ = r_s2 ^ r_clean;
    assign w_accept = w_differ && (r_cnt == c_cnt_max);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_cnt   <= '0;
            r_clean <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_s1   <= i_raw;
            r_s2   <= r_s1;
            // Strobes share the edge that updates r_clean so they align with it.
            r_rise <= w_accept & r_s2;
            r_fall <= w_accept & ~r_s2;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_clean <= r_s2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef SENSOR_GLITCH_LATCH_EN
    logic r_glitch;

    // A nonzero count that collapses back to the clean level was a rejected pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_glitch <= 1'b0;
        end else if (!w_differ && (r_cnt != '0)) begin
            r_glitch <= 1'b1;
        end else if (i_glitch_clr) begin
            r_glitch <= 1'b0;
        end
    end

    assign o_glitch = r_glitch;
`else
    logic w_unused_glitch_clr;
    assign w_unused_glitch_clr = i_glitch_clr;
    assign o_glitch            = 1'b0;
`endif

    assign o_clean = r_clean;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

`default_nettype wire

// File: rtl/sensor_conditioner.sv
// ============================================================================
// Module      : sensor_conditioner
// Description : Eight debounced sensor channels plus registered active count.
//               Optional glitch latching via SENSOR_GLITCH_LATCH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sensor_conditioner
    import sensor_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int NUM_SENSORS     = NUM_SENSORS_C
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SENSORS-1:0] sensor_raw,
    output logic [NUM_SENSORS-1:0] sensor_clean,
    output logic [NUM_SENSORS-1:0] rise_pulse,
    output logic [NUM_SENSORS-1:0] fall_pulse,
    output logic [ACT_CNT_W-1:0]   active_cnt,
    input  logic                   glitch_clr,
    output logic [NUM_SENSORS-1:0] glitch_flags
);

    logic [NUM_SENSORS-1:0] w_clean;
    logic [NUM_SENSORS-1:0] w_rise;
    logic [NUM_SENSORS-1:0] w_fall;
    logic [NUM_SENSORS-1:0] w_glitch;
    logic [ACT_CNT_W-1:0]   r_active_cnt;

    generate
        for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_ch
            sensor_debounce_ch #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_ch (
                .clk          (clk),
                .reset        (reset),
                .i_raw        (sensor_raw[i]),
                .i_glitch_clr (glitch_clr),
                .o_clean      (w_clean[i]),
                .o_rise       (w_rise[i]),
                .o_fall       (w_fall[i]),
                .o_glitch     (w_glitch[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_active_cnt <= '0;
        end else begin
            r_active_cnt <= popcount(w_clean);
        end
    end

    assign sensor_clean = w_clean;
    assign rise_pulse   = w_rise;
    assign fall_pulse   = w_fall;
    assign glitch_flags = w_glitch;
    assign active_cnt   = r_active_cnt;

endmodule

`default_nettype wire

// File: doc/sensor_conditioner.md
SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, giving consecutive stable cycles required to accept a change; legal range 2..255.
REQ-002 SHALL have parameter NUM_SENSORS, default 8, giving channel count; only 8 is supported.
REQ-003 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port sensor_raw, input, 8, asynchronous raw sensor levels (board pins).
REQ-006 SHALL have port sensor_clean, output, 8, debounced levels feeding the buzzer state machine's ui_in.
REQ-007 SHALL have port rise_pulse, output, 8, one-cycle strobe per channel on an accepted 0->1 change.
REQ-008 SHALL have port fall_pulse, output, 8, one-cycle strobe per channel on an accepted 1->0 change.
REQ-009 SHALL have port active_cnt, output, 4, count of channels with sensor_clean high (0..8).
REQ-010 SHALL have port glitch_clr, input, 1, synchronous clear of all glitch flags.
REQ-011 SHALL have port glitch_flags, output, 8, sticky per-channel rejected-pulse flags.

Function
REQ-012 Each channel SHALL pass sensor_raw through a 2-flop synchronizer (s1, s2) before any other use.
REQ-013 Each channel SHALL keep an 8-bit counter: cleared when s2 equals clean; incremented when s2 differs and counter < DEBOUNCE_CYCLES-1.
REQ-014 When s2 differs and counter == DEBOUNCE_CYCLES-1, the channel SHALL load clean <= s2 and clear the counter on the same edge.
REQ-015 Latency: with edge 1 the first edge sampling a new raw level, clean SHALL change on edge DEBOUNCE_CYCLES+2, given the level is held through that edge.
REQ-016 A raw level held for fewer than DEBOUNCE_CYCLES synchronized cycles SHALL never change sensor_clean or produce a pulse.
REQ-017 rise_pulse/fall_pulse SHALL be registered, high for exactly the one cycle in which sensor_clean first shows the new value.
REQ-018 Channels SHALL be independent; simultaneous changes on any subset SHALL be accepted on the same edge, with pulses on the same cycle.
REQ-019 active_cnt SHALL be the registered popcount of sensor_clean, lagging sensor_clean by one cycle.
REQ-020 Counter SHALL NOT wrap; it saturates at DEBOUNCE_CYCLES-1 only for the single accepting edge.

Reset
REQ-021 While reset is low, s1, s2, counters, sensor_clean, rise_pulse, fall_pulse, active_cnt and glitch_flags SHALL all be 0, regardless of clk.
REQ-022 Reset asserted mid-count SHALL discard partial counts; after release, a full DEBOUNCE_CYCLES+2 edges SHALL be required again.
REQ-023 No pulse SHALL be generated by reset release itself, even if sensor_raw is high.

Configuration
REQ-024 With SENSOR_GLITCH_LATCH_EN defined, glitch_flags[i] SHALL set on any edge where counter[i] != 0 and s2 returns to clean[i], and SHALL hold until glitch_clr; set wins over simultaneous clear.
REQ-025 Without SENSOR_GLITCH_LATCH_EN, glitch_flags SHALL be constant 0, glitch_clr ignored, and no flag registers synthesized.

Structure
REQ-026 Package sensor_cond_pkg SHALL hold NUM_SENSORS_C=8, DEB_CNT_W=8, DEBOUNCE_DEFAULT=4 and the active_cnt width.
REQ-027 Sub-module sensor_debounce_ch SHALL implement one channel (sync, counter, clean, pulses, glitch flag); top SHALL instantiate 8 via generate plus the popcount register.

Verification (DEBOUNCE_CYCLES=4, 10 ns clk)
REQ-028 reset low, sensor_raw=0xFF for 5 cycles -> all outputs 0 throughout; no pulse on release-edge.
REQ-029 sensor_raw[0] 0->1 held 10 cycles -> sensor_clean[0]=1 on edge 6, rise_pulse=0x01 for one cycle, active_cnt=1 one cycle later; return to 0 -> fall_pulse=0x01 six edges after.
REQ-030 sensor_raw[1] high 3 cycles then low -> sensor_clean/pulses unchanged; with macro glitch_flags=0x02 until glitch_clr, then 0x00.
REQ-031 sensor_raw 0x00->0xFF in one step -> sensor_clean=0xFF on edge 6, rise_pulse=0xFF one cycle, active_cnt=8; back to 0x00 -> fall_pulse=0xFF, active_cnt=0.
REQ-032 sensor_raw[2] high, reset pulsed low at edge 4 -> sensor_clean[2] stays 0 until edge 6 counted from reset release.
REQ-033 glitch event on channel 3 in the same cycle as glitch_clr (macro on) -> glitch_flags[3]=1.
